// File: rtl/sha3_app_arbiter.sv
// Two-requester arbiter in front of a SHA-3 core: grants one requester per message,
// routes its words to the core and hands the digest back under an ack/timeout guard.
module sha3_app_arbiter #(
    parameter int unsigned NumReq     = 2,
    parameter int unsigned MsgWidth   = 64,
    parameter int unsigned MsgStrbW   = 8,
    parameter int unsigned AckTimeout = 1024
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NumReq-1:0]                req_valid_i,
    input  logic [NumReq-1:0][MsgWidth-1:0]  req_data_i,
    input  logic [NumReq-1:0][MsgStrbW-1:0]  req_strb_i,
    input  logic [NumReq-1:0]                req_last_i,
    output logic [NumReq-1:0]                req_ready_o,
    output logic [NumReq-1:0]                req_done_o,
    input  logic [NumReq-1:0]                req_ack_i,
    output logic [NumReq-1:0]                req_err_o,
    output logic [NumReq-1:0]                grant_o,
    output logic                             msg_valid_o,
    output logic [MsgWidth-1:0]              msg_data_o,
    output logic [MsgStrbW-1:0]              msg_strb_o,
    input  logic                             msg_ready_i,
    output logic                             start_o,
    output logic                             process_o,
    output logic                             done_o,
    input  logic                             absorbed_i,
    input  logic                             squeezing_i,
    input  logic                             core_err_i,
    output logic                             busy_o
);

    // Pairwise Hamming distance >= 3 between all encodings.
    typedef enum logic [5:0] {
        StIdle   = 6'b000111,
        StStart  = 6'b011001,
        StMsg    = 6'b101010,
        StWait   = 6'b110100,
        StDigest = 6'b111111,
        StFlush  = 6'b000000
    } state_e;

    state_e              state_q, state_d;
    logic [NumReq-1:0]   grant_q, grant_d;
    logic                last_q, last_d;
    logic [31:0]         cnt_q, cnt_d;
    logic                process_q, process_d;
    logic                gidx;

    assign gidx      = grant_q[1];
    assign grant_o   = grant_q;
    assign process_o = process_q;
    assign busy_o    = (state_q != StIdle);

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        process_d   = 1'b0;
        start_o     = 1'b0;
        done_o      = 1'b0;
        req_err_o   = '0;
        req_ready_o = '0;
        req_done_o  = '0;
        msg_valid_o = 1'b0;
        msg_data_o  = '0;
        msg_strb_o  = '0;

        case (state_q)
            StIdle: begin
                if (|req_valid_i) begin
                    state_d = StStart;
                    if (&req_valid_i) begin
                        grant_d = last_q ? NumReq'(1) : NumReq'(2);
                    end else begin
                        grant_d = req_valid_i;
                    end
                end
            end
            StStart: begin
                start_o = 1'b1;
                state_d = StMsg;
            end
            StMsg: begin
                msg_valid_o       = req_valid_i[gidx];
                msg_data_o        = req_data_i[gidx];
                msg_strb_o        = req_strb_i[gidx];
                req_ready_o[gidx] = msg_ready_i;
                if (req_valid_i[gidx] && msg_ready_i && req_last_i[gidx]) begin
                    state_d   = StWait;
                    process_d = 1'b1;
                end
            end
            StWait: begin
                if (absorbed_i) begin
                    state_d = StDigest;
                end
            end
            StDigest: begin
                req_done_o[gidx] = squeezing_i;
                cnt_d            = cnt_q + 32'd1;
                if (req_ack_i[gidx]) begin
                    done_o  = 1'b1;
                    state_d = StFlush;
                end else if (cnt_q == AckTimeout - 1) begin
                    done_o    = 1'b1;
                    req_err_o = grant_q;
                    state_d   = StFlush;
                end
            end
            StFlush: begin
                grant_d = '0;
                last_d  = grant_q[1];
                cnt_d   = '0;
                state_d = StIdle;
            end
            default: begin
                state_d = StFlush;
            end
        endcase

        // Core error aborts the transaction; done_o only pulses if a digest was pending.
        if (core_err_i && (state_q != StIdle)) begin
            req_err_o = grant_q;
            process_d = 1'b0;
            done_o    = (state_q == StDigest);
            if (state_q != StFlush) begin
                state_d = StFlush;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            grant_q   <= '0;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            process_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            process_q <= process_d;
        end
    end

endmodule
